// File: rtl/aplic_msi_rx_pkg.sv
// aplic_msi_pkg: shared constants and types for the MSI responder.
//   FILE_M / FILE_S    : interrupt file indices (machine / supervisor).
//   SETEIPNUM_LE_OFF   : page offset of the seteipnum_le register.
//   req_fsm_e          : request/response FSM state encoding.
package aplic_msi_pkg;

  localparam int FILE_M = 0;
  localparam int FILE_S = 1;

  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    RST  = 2'd2
  } req_fsm_e;

endpackage

// File: rtl/aplic_msi_rx_if.sv
// aplic_msi_rx_if: MSI write request channel plus its write response.
//   i_msi_valid/o_msi_ready : request handshake, addr/data carried alongside.
//   o_rsp_valid/i_rsp_ready : response handshake, o_rsp_err = decode miss.
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds valid and its payload
// stable until that edge, and ready may not depend on valid combinationally.
interface aplic_msi_rx_if;

  logic        i_msi_valid;
  logic        o_msi_ready;
  logic [31:0] i_msi_addr;
  logic [31:0] i_msi_data;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic        i_rsp_ready;

  modport master (
    output i_msi_valid, i_msi_addr, i_msi_data, i_rsp_ready,
    input  o_msi_ready, o_rsp_valid, o_rsp_err
  );

  modport slave (
    input  i_msi_valid, i_msi_addr, i_msi_data, i_rsp_ready,
    output o_msi_ready, o_rsp_valid, o_rsp_err
  );

endinterface

// File: rtl/aplic_msi_rx_prio.sv
// aplic_msi_prio: combinational lowest-index priority encoder for one
// interrupt file.
//   eip  : pending bits, eie : enable bits (bit 0 is never a candidate).
//   thr  : threshold; 0 disables masking, otherwise only ids < thr qualify.
//   win  : lowest qualifying id, 0 when none.
module aplic_msi_prio #(
  parameter int NR_INTP = 64,
  parameter int ID_W    = $clog2(NR_INTP)
) (
  input  logic [NR_INTP-1:0] eip,
  input  logic [NR_INTP-1:0] eie,
  input  logic [ID_W-1:0]    thr,
  output logic [ID_W-1:0]    win
);

  // Scanning downward lets the lowest qualifying id overwrite higher ones.
  always_comb begin
    win = '0;
    for (int i = NR_INTP - 1; i >= 1; i--) begin
      if (eip[i] && eie[i] && ((thr == '0) || (i < int'(thr)))) begin
        win = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/aplic_msi_rx.sv
// aplic_msi_rx: receiving end of the APLIC MSI-mode write interface.
// Decodes seteipnum_le writes to the M or S page into a pending bit, keeps
// per-file enables, and presents a registered top identity and interrupt
// line per file with a claim port to retire the current top identity.
//   i_clk, i_rst        : clock, synchronous active-high reset.
//   msi                 : request/response channel (slave side).
//   i_eie_*             : enable bit write port.
//   i_eidelivery        : per-file delivery enable.
//   i_eithreshold       : per-file threshold, packed ID_W per file.
//   i_claim             : per-file claim pulse.
//   o_topei             : per-file top identity, packed ID_W per file.
//   o_Xeip_targets      : per-file external interrupt line.
//   o_dbg_state         : request FSM state.
module aplic_msi_rx
  import aplic_msi_pkg::*;
#(
  parameter int          NR_INTP  = 64,
  parameter int          NR_FILES = 2,
  parameter logic [31:0] M_BASE   = 32'h2400_0000,
  parameter logic [31:0] S_BASE   = 32'h2800_0000,
  localparam int         ID_W     = $clog2(NR_INTP),
  localparam int         FILE_W   = (NR_FILES > 1) ? $clog2(NR_FILES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  aplic_msi_rx_if.slave            msi,
  input  logic                     i_eie_we,
  input  logic [FILE_W-1:0]        i_eie_file,
  input  logic [ID_W-1:0]          i_eie_id,
  input  logic                     i_eie_val,
  input  logic [NR_FILES-1:0]      i_eidelivery,
  input  logic [NR_FILES*ID_W-1:0] i_eithreshold,
  input  logic [NR_FILES-1:0]      i_claim,
  output logic [NR_FILES*ID_W-1:0] o_topei,
  output logic [NR_FILES-1:0]      o_Xeip_targets,
  output req_fsm_e                 o_dbg_state
);

  req_fsm_e state_q;
  logic     ready_q;
  logic     rsp_valid_q;
  logic     rsp_err_q;

  logic [NR_FILES-1:0][NR_INTP-1:0] eip;
  logic [NR_FILES-1:0][NR_INTP-1:0] eie;
  logic [NR_FILES-1:0][ID_W-1:0]    win;
  logic [NR_FILES-1:0][ID_W-1:0]    topei_q;
  logic [NR_FILES-1:0]              xeip_q;

  logic              addr_hit;
  logic [FILE_W-1:0] hit_file;
  logic              id_ok;
  logic [ID_W-1:0]   msi_id;
  logic              accept;

  // Only the seteipnum_le word of each page is decoded.
  always_comb begin
    addr_hit = 1'b0;
    hit_file = '0;
    if (msi.i_msi_addr == (M_BASE + 32'(SETEIPNUM_LE_OFF))) begin
      addr_hit = 1'b1;
      hit_file = FILE_W'(FILE_M);
    end else if (msi.i_msi_addr == (S_BASE + 32'(SETEIPNUM_LE_OFF))) begin
      addr_hit = 1'b1;
      hit_file = FILE_W'(FILE_S);
    end
  end

  // Full-width compare rejects id 0, ids >= NR_INTP and nonzero upper bits.
  assign id_ok  = (msi.i_msi_data != 32'd0) && (msi.i_msi_data < 32'(NR_INTP));
  assign msi_id = msi.i_msi_data[ID_W-1:0];
  assign accept = msi.i_msi_valid && ready_q;

  // Request FSM with registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RST;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RST: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        IDLE: begin
          if (msi.i_msi_valid) begin
            state_q     <= RESP;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ~addr_hit;
          end
        end
        RESP: begin
          if (msi.i_rsp_ready) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= RST;
          ready_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Pending/enable state and registered priority outputs. The MSI set is
  // written after the claim clear so a same-cycle set of that bit wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      eip     <= '0;
      eie     <= '0;
      topei_q <= '0;
      xeip_q  <= '0;
    end else begin
      if (i_eie_we && (i_eie_id != '0) && (int'(i_eie_file) < NR_FILES)) begin
        eie[i_eie_file][i_eie_id] <= i_eie_val;
      end
      for (int f = 0; f < NR_FILES; f++) begin
        if (i_claim[f] && (topei_q[f] != '0)) begin
          eip[f][topei_q[f]] <= 1'b0;
        end
      end
      if (accept && addr_hit && id_ok) begin
        eip[hit_file][msi_id] <= 1'b1;
      end
      for (int f = 0; f < NR_FILES; f++) begin
        topei_q[f] <= win[f];
        xeip_q[f]  <= i_eidelivery[f] && (win[f] != '0);
      end
    end
  end

  for (genvar g = 0; g < NR_FILES; g++) begin : g_file
    aplic_msi_prio #(
      .NR_INTP (NR_INTP),
      .ID_W    (ID_W)
    ) u_prio (
      .eip (eip[g]),
      .eie (eie[g]),
      .thr (i_eithreshold[g*ID_W +: ID_W]),
      .win (win[g])
    );
    assign o_topei[g*ID_W +: ID_W] = topei_q[g];
  end

  assign o_Xeip_targets  = xeip_q;
  assign msi.o_msi_ready = ready_q;
  assign msi.o_rsp_valid = rsp_valid_q;
  assign msi.o_rsp_err   = rsp_err_q;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_aplic_msi_rx.sv
// tb_aplic_msi_rx: self-checking bench for aplic_msi_rx. Expected response
// error flags are queued when a request is driven and popped when the
// response appears; priority outputs are checked against hand-derived ids.
module tb_aplic_msi_rx;
  import aplic_msi_pkg::*;

  localparam logic [31:0] M_BASE = 32'h2400_0000;
  localparam logic [31:0] S_BASE = 32'h2800_0000;

  logic        clk;
  logic        rst;
  logic        eie_we;
  logic [0:0]  eie_file;
  logic [5:0]  eie_id;
  logic        eie_val;
  logic [1:0]  eidelivery;
  logic [11:0] eithreshold;
  logic [1:0]  claim;
  logic [11:0] topei;
  logic [1:0]  xeip;
  req_fsm_e    dbg_state;

  logic [0:0] exp_q[$];
  int n_tests;
  int n_fail;

  aplic_msi_rx_if msi_if ();

  aplic_msi_rx dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .msi            (msi_if),
    .i_eie_we       (eie_we),
    .i_eie_file     (eie_file),
    .i_eie_id       (eie_id),
    .i_eie_val      (eie_val),
    .i_eidelivery   (eidelivery),
    .i_eithreshold  (eithreshold),
    .i_claim        (claim),
    .o_topei        (topei),
    .o_Xeip_targets (xeip),
    .o_dbg_state    (dbg_state)
  );

  wire [5:0] topei_m = topei[5:0];
  wire [5:0] topei_s = topei[11:6];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_eie(input int f, input int id, input logic v);
    eie_we   = 1'b1;
    eie_file = 1'(f);
    eie_id   = 6'(id);
    eie_val  = v;
    @(negedge clk);
    eie_we = 1'b0;
  endtask

  task automatic do_claim(input int f);
    claim[f] = 1'b1;
    @(negedge clk);
    claim = 2'b00;
  endtask

  // One request with i_rsp_ready held high; the response flag is scored.
  task automatic send_msi(input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err);
    int k;
    logic [0:0] e;
    exp_q.push_back(exp_err);
    msi_if.i_msi_valid = 1'b1;
    msi_if.i_msi_addr  = addr;
    msi_if.i_msi_data  = data;
    k = 0;
    while (!msi_if.o_msi_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (msi_if.o_msi_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL msi_accept_timeout addr=%h got_ready=%b exp=1", addr, msi_if.o_msi_ready);
      msi_if.i_msi_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    msi_if.i_msi_valid = 1'b0;
    k = 0;
    while (!msi_if.o_rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    e = exp_q.pop_front();
    if (msi_if.o_rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL msi_rsp_timeout addr=%h got_valid=%b exp=1", addr, msi_if.o_rsp_valid);
    end else if (msi_if.o_rsp_err !== e) begin
      n_fail++;
      $display("FAIL msi_rsp_err addr=%h data=%h got=%b exp=%b", addr, data, msi_if.o_rsp_err, e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (msi_if.o_msi_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", msi_if.o_msi_ready); end
    n_tests++; if (msi_if.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", msi_if.o_rsp_valid); end
    n_tests++; if (msi_if.o_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", msi_if.o_rsp_err); end
    n_tests++; if (topei !== 12'd0) begin n_fail++; $display("FAIL reset_topei got=%h exp=0", topei); end
    n_tests++; if (xeip !== 2'b00) begin n_fail++; $display("FAIL reset_xeip got=%b exp=00", xeip); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (msi_if.o_msi_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", msi_if.o_msi_ready); end
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_release_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_s_file();
    set_eie(1, 5, 1'b1);
    eidelivery = 2'b10;
    send_msi(S_BASE, 32'd5, 1'b0);
    n_tests++; if (topei_s !== 6'd5) begin n_fail++; $display("FAIL s_topei got=%0d exp=5", topei_s); end
    n_tests++; if (xeip[1] !== 1'b1) begin n_fail++; $display("FAIL s_xeip got=%b exp=1", xeip[1]); end
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL s_m_topei got=%0d exp=0", topei_m); end
    n_tests++; if (xeip[0] !== 1'b0) begin n_fail++; $display("FAIL s_m_xeip got=%b exp=0", xeip[0]); end
    do_claim(1);
    wait_cycles(1);
    n_tests++; if (topei_s !== 6'd0) begin n_fail++; $display("FAIL s_claim_topei got=%0d exp=0", topei_s); end
    n_tests++; if (xeip[1] !== 1'b0) begin n_fail++; $display("FAIL s_claim_xeip got=%b exp=0", xeip[1]); end
  endtask

  task automatic test_decode_miss();
    send_msi(S_BASE + 32'd4, 32'd5, 1'b1);
    send_msi(M_BASE + 32'h1000, 32'd5, 1'b1);
    wait_cycles(1);
    n_tests++; if (topei_s !== 6'd0) begin n_fail++; $display("FAIL miss_topei got=%0d exp=0", topei_s); end
    n_tests++; if (xeip[1] !== 1'b0) begin n_fail++; $display("FAIL miss_xeip got=%b exp=0", xeip[1]); end
  endtask

  task automatic test_invalid_id();
    set_eie(0, 5, 1'b1);
    eidelivery = 2'b11;
    send_msi(M_BASE, 32'd0, 1'b0);
    send_msi(M_BASE, 32'd64, 1'b0);
    send_msi(M_BASE, 32'h8000_0005, 1'b0);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL badid_topei got=%0d exp=0", topei_m); end
    n_tests++; if (xeip[0] !== 1'b0) begin n_fail++; $display("FAIL badid_xeip got=%b exp=0", xeip[0]); end
    set_eie(0, 5, 1'b0);
  endtask

  task automatic test_priority();
    set_eie(0, 3, 1'b1);
    set_eie(0, 9, 1'b1);
    send_msi(M_BASE, 32'd9, 1'b0);
    send_msi(M_BASE, 32'd3, 1'b0);
    n_tests++; if (topei_m !== 6'd3) begin n_fail++; $display("FAIL prio_thr0 got=%0d exp=3", topei_m); end
    n_tests++; if (xeip[0] !== 1'b1) begin n_fail++; $display("FAIL prio_thr0_xeip got=%b exp=1", xeip[0]); end
    eithreshold[5:0] = 6'd3;
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL prio_thr3 got=%0d exp=0", topei_m); end
    n_tests++; if (xeip[0] !== 1'b0) begin n_fail++; $display("FAIL prio_thr3_xeip got=%b exp=0", xeip[0]); end
    eithreshold[5:0] = 6'd10;
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd3) begin n_fail++; $display("FAIL prio_thr10 got=%0d exp=3", topei_m); end
    do_claim(0);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd9) begin n_fail++; $display("FAIL prio_claim1 got=%0d exp=9", topei_m); end
    n_tests++; if (xeip[0] !== 1'b1) begin n_fail++; $display("FAIL prio_claim1_xeip got=%b exp=1", xeip[0]); end
    do_claim(0);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL prio_claim2 got=%0d exp=0", topei_m); end
    n_tests++; if (xeip[0] !== 1'b0) begin n_fail++; $display("FAIL prio_claim2_xeip got=%b exp=0", xeip[0]); end
    eithreshold = 12'd0;
  endtask

  task automatic test_rsp_hold();
    logic [0:0] e;
    msi_if.i_rsp_ready = 1'b0;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    msi_if.i_msi_valid = 1'b1;
    msi_if.i_msi_addr  = M_BASE;
    msi_if.i_msi_data  = 32'd20;
    n_tests++; if (msi_if.o_msi_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready got=%b exp=1", msi_if.o_msi_ready); end
    @(posedge clk);
    @(negedge clk);
    // Second request is presented immediately and must wait.
    msi_if.i_msi_addr = S_BASE + 32'd8;
    msi_if.i_msi_data = 32'd1;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (msi_if.o_msi_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d got=%b exp=0", i, msi_if.o_msi_ready); end
      n_tests++; if (msi_if.o_rsp_valid !== 1'b1 || msi_if.o_rsp_err !== exp_q[0]) begin
        n_fail++; $display("FAIL hold_rsp c%0d got=%b/%b exp=1/%b", i, msi_if.o_rsp_valid, msi_if.o_rsp_err, exp_q[0]);
      end
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    msi_if.i_rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (msi_if.o_msi_ready !== 1'b1 || msi_if.o_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_after_hs got=%b/%b exp=1/0", msi_if.o_msi_ready, msi_if.o_rsp_valid);
    end
    @(negedge clk);
    msi_if.i_msi_valid = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if (msi_if.o_rsp_valid !== 1'b1 || msi_if.o_rsp_err !== e || msi_if.o_msi_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_second got=%b/%b/%b exp=1/%b/0", msi_if.o_rsp_valid, msi_if.o_rsp_err, msi_if.o_msi_ready, e);
    end
    @(negedge clk);
  endtask

  task automatic test_claim_race();
    logic [0:0] e;
    set_eie(0, 7, 1'b1);
    send_msi(M_BASE, 32'd7, 1'b0);
    n_tests++; if (topei_m !== 6'd7) begin n_fail++; $display("FAIL race_pre got=%0d exp=7", topei_m); end
    exp_q.push_back(1'b0);
    msi_if.i_msi_valid = 1'b1;
    msi_if.i_msi_addr  = M_BASE;
    msi_if.i_msi_data  = 32'd7;
    claim = 2'b01;
    n_tests++; if (msi_if.o_msi_ready !== 1'b1) begin n_fail++; $display("FAIL race_ready got=%b exp=1", msi_if.o_msi_ready); end
    @(negedge clk);
    msi_if.i_msi_valid = 1'b0;
    claim = 2'b00;
    e = exp_q.pop_front();
    n_tests++; if (msi_if.o_rsp_valid !== 1'b1 || msi_if.o_rsp_err !== e) begin
      n_fail++; $display("FAIL race_rsp got=%b/%b exp=1/%b", msi_if.o_rsp_valid, msi_if.o_rsp_err, e);
    end
    @(negedge clk);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd7) begin n_fail++; $display("FAIL race_topei got=%0d exp=7", topei_m); end
    n_tests++; if (xeip[0] !== 1'b1) begin n_fail++; $display("FAIL race_xeip got=%b exp=1", xeip[0]); end
    do_claim(0);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL race_cleanup got=%0d exp=0", topei_m); end
  endtask

  task automatic test_reset_mid();
    send_msi(M_BASE, 32'd3, 1'b0);
    n_tests++; if (topei_m !== 6'd3) begin n_fail++; $display("FAIL rstmid_pre got=%0d exp=3", topei_m); end
    msi_if.i_rsp_ready = 1'b0;
    msi_if.i_msi_valid = 1'b1;
    msi_if.i_msi_addr  = M_BASE;
    msi_if.i_msi_data  = 32'd9;
    @(posedge clk);
    @(negedge clk);
    msi_if.i_msi_valid = 1'b0;
    n_tests++; if (msi_if.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_rsp got=%b exp=1", msi_if.o_rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (msi_if.o_msi_ready !== 1'b0 || msi_if.o_rsp_valid !== 1'b0 || msi_if.o_rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hs got=%b/%b/%b exp=0/0/0", msi_if.o_msi_ready, msi_if.o_rsp_valid, msi_if.o_rsp_err);
    end
    n_tests++; if (topei !== 12'd0 || xeip !== 2'b00) begin n_fail++; $display("FAIL rstmid_prio got=%h/%b exp=0/00", topei, xeip); end
    n_tests++; if (dbg_state !== RST) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, RST); end
    exp_q.delete();
    msi_if.i_rsp_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (msi_if.o_msi_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release got=%b exp=1", msi_if.o_msi_ready); end
    // Enables were cleared by reset, so a new pending bit is not delivered.
    send_msi(M_BASE, 32'd3, 1'b0);
    wait_cycles(1);
    n_tests++; if (topei_m !== 6'd0) begin n_fail++; $display("FAIL rstmid_eie_cleared got=%0d exp=0", topei_m); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    eie_we = 1'b0;
    eie_file = 1'b0;
    eie_id = 6'd0;
    eie_val = 1'b0;
    eidelivery = 2'b00;
    eithreshold = 12'd0;
    claim = 2'b00;
    msi_if.i_msi_valid = 1'b0;
    msi_if.i_msi_addr  = 32'd0;
    msi_if.i_msi_data  = 32'd0;
    msi_if.i_rsp_ready = 1'b1;

    test_reset();
    test_s_file();
    test_decode_miss();
    test_invalid_id();
    test_priority();
    test_rsp_hold();
    test_claim_race();
    test_reset_mid();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aplic_msi_rx.md
# aplic_msi_rx

MSI responder that receives the MSI writes the APLIC emits in MSI mode, so it is the receiving end of that interface. It decodes each write into an interrupt file (M or S) and an interrupt identity, then sets the matching pending bit. It keeps enable and threshold state for each file and drives one external-interrupt line per file. It also exposes a registered top-identity output and a claim port per file, so hart-side logic can read and clear the highest-priority pending interrupt.

## Interface
- NR_INTP, 64: number of identities per file; identity 0 is reserved and never pending.
- NR_FILES, 2: interrupt files; index 0 = M, index 1 = S.
- M_BASE, 32'h2400_0000: 4 KiB-aligned page address of the M file.
- S_BASE, 32'h2800_0000: 4 KiB-aligned page address of the S file.
- ID_W, $clog2(NR_INTP): identity width (derived).
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, synchronous and active-high.
- i_msi_valid  in  1  MSI write request valid.
- o_msi_ready  out  1  MSI write request ready.
- i_msi_addr  in  32  write address.
- i_msi_data  in  32  write data; identity = data[ID_W-1:0] when data[31:ID_W]==0.
- o_rsp_valid  out  1  write response valid.
- o_rsp_err  out  1  response error (address decode miss).
- i_rsp_ready  in  1  response accept.
- i_eie_we  in  1  enable-bit write strobe.
- i_eie_file  in  $clog2(NR_FILES)  file selected by i_eie_we.
- i_eie_id  in  ID_W  identity selected by i_eie_we.
- i_eie_val  in  1  enable value written.
- i_eidelivery  in  NR_FILES  per-file delivery enable.
- i_eithreshold  in  NR_FILES×ID_W  per-file threshold; 0 = none.
- i_claim  in  NR_FILES  per-file claim pulse.
- o_topei  out  NR_FILES×ID_W  highest-priority deliverable identity; 0 = none.
- o_Xeip_targets  out  NR_FILES  per-file interrupt line.

## Operation
- Address decode:
  - Hit means i_msi_addr equals M_BASE or S_BASE exactly, i.e. offset 0 = seteipnum_le.
  - Any other address is a miss: no state change, o_rsp_err=1.
- Identity validity:
  - Identity 0, identity ≥ NR_INTP, or nonzero upper data bits: write completes with err=0 and no state change.
- Valid hit: eip[file][id] is set.
- Only one request is outstanding at a time:
  - o_msi_ready=0 from the accept edge until the response handshake completes.
  - The request FSM has three states:
    - IDLE (ready=1): on valid, go to RESP.
    - RESP (rsp_valid=1): on i_rsp_ready, go to IDLE.
    - RST: held while i_rst; goes to IDLE on the first cycle after release.
- Enables: eie[file][id] is written by i_eie_we; writes to identity 0 are ignored.
- Priority:
  - The candidate set per file is {id : eip & eie, id≠0, and (thr==0 or id<thr)}.
  - The winner is the lowest id in the set; o_topei is the winner, or 0 if the set is empty.
- o_Xeip_targets[f] = i_eidelivery[f] & (o_topei[f]!=0).
- Claim:
  - i_claim[f] clears eip[f][o_topei[f]] at the next edge.
  - Claim while o_topei[f]==0: no effect.
- Simultaneous MSI set and claim clear of the same bit: set wins, bit stays pending.
- Set of an already-pending bit: idempotent.

## Timing
- Reset values:
  - o_msi_ready=0, o_rsp_valid=0, o_rsp_err=0.
  - o_topei=0, o_Xeip_targets=0.
  - All eip and eie bits = 0.
- o_msi_ready is 1 on the first cycle after i_rst deasserts.
- Accept at edge N (valid&ready): eip updated at N, o_rsp_valid=1 from N+1.
- Throughput:
  - Minimum 2 cycles per MSI when i_rsp_ready is held high.
  - The response is registered and held stable while i_rsp_ready=0.
- Latency of o_topei and o_Xeip_targets:
  - Registered; they reflect eip, eie, threshold and delivery state one cycle after that state changes.
  - End to end, the accept edge N gives o_Xeip_targets high at N+1.
- Claim at edge C:
  - The bit clears at C.
  - o_topei shows the next winner from C+1.
  - Back-to-back claims in consecutive cycles are permitted; each claims the then-current o_topei.
- i_rst asserted mid-transaction: any outstanding response is dropped, and all state returns to reset values at the next edge.

## Structure
- Package aplic_msi_pkg holds:
  - The file index constants FILE_M=0 and FILE_S=1.
  - The seteipnum_le offset constant (0).
  - A req_fsm_e enum with states IDLE, RESP and RST.
- Sub-module aplic_msi_prio: per-file combinational lowest-index priority encoder with threshold masking. It is instantiated NR_FILES times; the top registers its output.

## Test plan
- MSI to S_BASE with data=5, eie[S][5]=1, eidelivery[S]=1:
  - o_rsp_valid with err=0.
  - o_topei[S]=5, o_Xeip_targets[S]=1, M outputs unaffected.
- MSI to S_BASE+4:
  - o_rsp_err=1, no pending change, o_Xeip_targets stays 0.
- Pending ids 3 and 9 in M, both enabled, threshold 0 → o_topei[M]=3.
  - Threshold 3: o_topei[M]=0.
  - Threshold 10, claim: topei goes 3→9; second claim → 0 and Xeip drops.
- Data=0, data=NR_INTP and data=32'h8000_0005:
  - Each completes with err=0 and nothing goes pending.
- i_rsp_ready held 0 for 5 cycles:
  - o_msi_ready stays 0 and the response stays stable.
  - A second request is accepted only after the handshake.
- Claim of id 7 in the same cycle as a new MSI for id 7:
  - id 7 stays pending and o_topei[M] stays 7.
- Reset asserted while o_rsp_valid=1: all outputs are 0 at the next edge and o_msi_ready=1 one cycle after release.
